sv_fetch_ctrl: RTL

Sequencer that owns the single-port support-vector RAM (`support_vectors`, 32-bit data, 6-bit address, registered read, shared tri-state data bus). It loads vectors through a valid/ready load port and streams a requested range of words to the SVM kernel datapath through a valid/ready output port. Loads and fetches never overlap on the RAM, and the block is the only master of the RAM `cs`, `we`, `oe` and `address` pins.

---
 rtl/sv_fetch_ctrl_if.sv | 39 +++
 rtl/sv_fetch_ctrl.sv | 132 +++++++++++++
 2 files changed

// File: rtl/sv_fetch_ctrl_if.sv
// Load port, fetch command/stream port and RAM control pins of the
// support-vector fetch sequencer. The shared RAM data bus is a separate
// inout on the block itself.
interface sv_fetch_ctrl_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
);
   logic                  ld_valid;
   logic                  ld_ready;
   logic [ADDR_WIDTH-1:0] ld_addr;
   logic [DATA_WIDTH-1:0] ld_data;
   logic                  start;
   logic [ADDR_WIDTH-1:0] base;
   logic [ADDR_WIDTH:0]   count;
   logic                  busy;
   logic                  done;
   logic                  sv_valid;
   logic                  sv_ready;
   logic [DATA_WIDTH-1:0] sv_data;
   logic                  sv_last;
   logic [ADDR_WIDTH-1:0] ram_address;
   logic                  ram_cs;
   logic                  ram_we;
   logic                  ram_oe;

   // environment side: issues loads/fetches, consumes words, owns the RAM
   modport master (
      output ld_valid, ld_addr, ld_data, start, base, count, sv_ready,
      input  ld_ready, busy, done, sv_valid, sv_data, sv_last,
      input  ram_address, ram_cs, ram_we, ram_oe
   );

   // sequencer side
   modport slave (
      input  ld_valid, ld_addr, ld_data, start, base, count, sv_ready,
      output ld_ready, busy, done, sv_valid, sv_data, sv_last,
      output ram_address, ram_cs, ram_we, ram_oe
   );
endinterface

// File: rtl/sv_fetch_ctrl.sv
// Support-vector RAM sequencer: serialises loads and range fetches onto a
// single-port registered-read RAM and streams fetched words over valid/ready.
module sv_fetch_ctrl #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   sv_fetch_ctrl_if.slave        bus,
   inout  wire  [DATA_WIDTH-1:0] ram_data
);
   typedef enum logic [2:0] {
      S_IDLE, S_WRITE, S_RD_ADDR, S_RD_DATA, S_HOLD, S_DONE
   } state_t;

   localparam logic [ADDR_WIDTH:0] REM_ONE = (ADDR_WIDTH+1)'(1);

   state_t                st;
   logic [ADDR_WIDTH-1:0] addr_cnt;
   logic [ADDR_WIDTH:0]   rem;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] wr_data_q;
   logic [DATA_WIDTH-1:0] sv_data_q;
   logic                  drive_q, cs_q, we_q, oe_q;
   logic                  busy_q, done_q, valid_q, last_q;

   // Bus is driven only during WRITE, so it can never fight the RAM's read drive.
   assign ram_data = drive_q ? wr_data_q : {DATA_WIDTH{1'bz}};

   assign bus.ld_ready    = (st == S_IDLE) && !bus.start;
   assign bus.busy        = busy_q;
   assign bus.done        = done_q;
   assign bus.sv_valid    = valid_q;
   assign bus.sv_data     = sv_data_q;
   assign bus.sv_last     = last_q;
   assign bus.ram_address = addr_q;
   assign bus.ram_cs      = cs_q;
   assign bus.ram_we      = we_q;
   assign bus.ram_oe      = oe_q;

   // Sequencer FSM; every output is registered and set up for the state being entered.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st        <= S_IDLE;
         addr_cnt  <= '0;
         rem       <= '0;
         addr_q    <= '0;
         wr_data_q <= '0;
         sv_data_q <= '0;
         drive_q   <= 1'b0;
         cs_q      <= 1'b0;
         we_q      <= 1'b0;
         oe_q      <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         valid_q   <= 1'b0;
         last_q    <= 1'b0;
      end else begin
         case (st)
            S_IDLE: begin
               // start wins over a simultaneous load; that load stays pending
               if (bus.start) begin
                  addr_cnt <= bus.base;
                  rem      <= bus.count;
                  busy_q   <= 1'b1;
                  if (bus.count == '0) begin
                     st     <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     st     <= S_RD_ADDR;
                     cs_q   <= 1'b1;
                     oe_q   <= 1'b1;
                     addr_q <= bus.base;
                  end
               end else if (bus.ld_valid) begin
                  st        <= S_WRITE;
                  addr_q    <= bus.ld_addr;
                  wr_data_q <= bus.ld_data;
                  cs_q      <= 1'b1;
                  we_q      <= 1'b1;
                  drive_q   <= 1'b1;
                  busy_q    <= 1'b1;
               end
            end
            S_WRITE: begin
               st      <= S_IDLE;
               addr_q  <= '0;
               cs_q    <= 1'b0;
               we_q    <= 1'b0;
               drive_q <= 1'b0;
               busy_q  <= 1'b0;
            end
            S_RD_ADDR: begin
               // RAM registers the word at this edge; controls held for the drive cycle
               st <= S_RD_DATA;
            end
            S_RD_DATA: begin
               st        <= S_HOLD;
               sv_data_q <= ram_data;
               last_q    <= (rem == REM_ONE);
               valid_q   <= 1'b1;
               cs_q      <= 1'b0;
               oe_q      <= 1'b0;
               addr_q    <= '0;
            end
            S_HOLD: begin
               if (bus.sv_ready) begin
                  valid_q  <= 1'b0;
                  last_q   <= 1'b0;
                  addr_cnt <= addr_cnt + 1'b1;
                  rem      <= rem - REM_ONE;
                  if (rem == REM_ONE) begin
                     st     <= S_DONE;
                     done_q <= 1'b1;
                  end else begin
                     st     <= S_RD_ADDR;
                     cs_q   <= 1'b1;
                     oe_q   <= 1'b1;
                     addr_q <= addr_cnt + 1'b1;
                  end
               end
            end
            S_DONE: begin
               st     <= S_IDLE;
               done_q <= 1'b0;
               busy_q <= 1'b0;
            end
            default: st <= S_IDLE;
         endcase
      end
   end
endmodule
